branch_predict_unit: RTL

Parametrised branch resolution and prediction block for the RISC-V core.
- Resolves the six RV32I/RV64I conditional-branch comparisons at XLEN width.
- Keeps a table of 2-bit saturating counters (BHT), indexed by PC, that supplies fetch-stage taken/not-taken predictions.
- Detects mispredictions and produces the redirect PC for the fetch stage.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit BHT direction prediction with mispredict redirect
// and saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pred_req,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   br_data_a,
    input  logic [XLEN-1:0]   br_data_b,
    input  logic [XLEN-1:0]   res_target,
    input  logic              res_pred_taken,
    output logic              res_done,
    output logic              res_taken,
    output logic              res_mispredict,
    output logic              res_illegal,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned BHT_N = 1 << BHT_IDX_W;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] pred_idx;
    logic [BHT_IDX_W-1:0] res_idx;
    logic                 cmp_taken;
    logic                 cmp_legal;
    logic                 res_fire;
    logic                 bht_we;
    logic                 mispredict;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_next;
    logic [1:0]           pred_ctr;
    logic [XLEN-1:0]      redirect_next;
    logic                 unused_pred_pc_bits;

    assign pred_idx = pred_pc[BHT_IDX_W+1:2];
    assign res_idx  = res_pc[BHT_IDX_W+1:2];

    // Only the index field of the prediction PC addresses the table.
    assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0]};

    // Branch condition evaluation at full XLEN width.
    always_comb begin
        cmp_taken = 1'b0;
        cmp_legal = 1'b1;
        case (funct3)
            F3_BEQ:  cmp_taken = (br_data_a == br_data_b);
            F3_BNE:  cmp_taken = (br_data_a != br_data_b);
            F3_BLT:  cmp_taken = ($signed(br_data_a) <  $signed(br_data_b));
            F3_BGE:  cmp_taken = ($signed(br_data_a) >= $signed(br_data_b));
            F3_BLTU: cmp_taken = (br_data_a <  br_data_b);
            F3_BGEU: cmp_taken = (br_data_a >= br_data_b);
            default: begin
                cmp_taken = 1'b0;
                cmp_legal = 1'b0;
            end
        endcase
    end

    assign res_fire      = res_valid & ~flush;
    assign bht_we        = res_fire & cmp_legal;
    assign mispredict    = cmp_taken ^ res_pred_taken;
    assign redirect_next = cmp_taken ? res_target : res_pc + XLEN'(4);
    assign ctr_cur       = bht[res_idx];

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        ctr_next = ctr_cur;
        if (cmp_taken) begin
            if (ctr_cur != 2'b11) begin
                ctr_next = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_next = ctr_cur - 2'd1;
            end
        end
    end

    // Write-first: a same-cycle update to the predicted entry is visible to fetch.
    assign pred_ctr = (bht_we && (res_idx == pred_idx)) ? ctr_next : bht[pred_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (bht_we) begin
            bht[res_idx] <= ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            res_done       <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_illegal    <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            pred_valid     <= pred_req & ~flush;
            pred_taken     <= pred_req & ~flush & pred_ctr[1];
            res_done       <= res_fire;
            res_taken      <= res_fire & cmp_taken;
            res_mispredict <= res_fire & mispredict;
            res_illegal    <= res_fire & ~cmp_legal;
            redirect_pc    <= redirect_next;
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bht_we && (stat_branches != '1)) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (res_fire && mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
            end
        end
    end

endmodule
